// File: rtl/alu_pkg.sv
// Shared ALU encodings: sequencer states, add/subtract mode and the signed-overflow rule.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // Overflow needs the operand MSBs as they were at load time, not the shifted-out copies.
    function automatic logic signed_ovf(input logic mode,
                                        input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
        logic ovf;
        if (mode == MODE_ADD) begin
            ovf = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            ovf = (a_msb != b_msb) && (r_msb != a_msb);
        end
        return ovf;
    endfunction

endpackage

// File: rtl/digit_addsub.sv
// Combinational DIGIT-bit ripple of full-adder / full-subtractor cells, LSB first.
module digit_addsub
    import alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    input  logic             mode,
    output logic [DIGIT-1:0] out,
    output logic             cout
);

    logic [DIGIT:0] chain_s;

    // Ripple the carry/borrow through the digit; chain_s[0] is the registered chain bit.
    always_comb begin
        chain_s    = '0;
        out        = '0;
        chain_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            out[i] = x[i] ^ y[i] ^ chain_s[i];
            if (mode == MODE_ADD) begin
                chain_s[i+1] = (x[i] & y[i]) | (y[i] & chain_s[i]) | (x[i] & chain_s[i]);
            end else begin
                chain_s[i+1] = (~x[i] & y[i]) | (y[i] & chain_s[i]) | (~x[i] & chain_s[i]);
            end
        end
    end

    assign cout = chain_s[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: WIDTH/DIGIT cycles per operation, carry/borrow chain held in a register.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_addsub: DIGIT must be at least 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
            $error("serial_addsub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             chain_q;
    logic             mode_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic [DIGIT-1:0] digit_d;
    logic             chain_d;
    logic [WIDTH-1:0] res_d;
    logic             accept_s;

    digit_addsub #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x    (a_sh_q[DIGIT-1:0]),
        .y    (b_sh_q[DIGIT-1:0]),
        .cin  (chain_q),
        .mode (mode_q),
        .out  (digit_d),
        .cout (chain_d)
    );

    // New digit enters from the MSB side so the first digit ends up at the bottom after N shifts.
    assign res_d = WIDTH'({digit_d, res_sh_q} >> DIGIT);

    // A request is only honoured when no operation is in flight.
    always_comb begin
        if (start && ((state_q == IDLE) || (state_q == DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer, operand/result shifters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            chain_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_s) begin
                state_q  <= RUN;
                busy     <= 1'b1;
                a_sh_q   <= a;
                b_sh_q   <= b;
                a_msb_q  <= a[WIDTH-1];
                b_msb_q  <= b[WIDTH-1];
                mode_q   <= mode;
                chain_q  <= bin;
                cnt_q    <= '0;
                res_sh_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    RUN: begin
                        a_sh_q   <= a_sh_q >> DIGIT;
                        b_sh_q   <= b_sh_q >> DIGIT;
                        res_sh_q <= res_d;
                        chain_q  <= chain_d;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= res_d;
                            bout    <= chain_d;
                            ovf     <= signed_ovf(mode_q, a_msb_q, b_msb_q, res_d[WIDTH-1]);
                            zero    <= ~|res_d;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at DIGIT = 1, 4 and 8 against an integer-arithmetic model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode, bin;
    logic [7:0] a, b;
    logic       start1, start4, start8;

    logic       busy1, done1, bout1, ovf1, zero1;
    logic       busy4, done4, bout4, ovf4, zero4;
    logic       busy8, done8, bout8, ovf8, zero8;
    logic [7:0] res1, res4, res8;

    typedef struct {
        logic [7:0] res;
        logic       bout;
        logic       ovf;
        logic       zero;
        int         due;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q8[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .result(res1), .bout(bout1), .ovf(ovf1), .zero(zero1));

    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .result(res4), .bout(bout4), .ovf(ovf4), .zero(zero4));

    serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .a(a), .b(b), .bin(bin),
        .busy(busy8), .done(done8), .result(res8), .bout(bout8), .ovf(ovf8), .zero(zero8));

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic m, input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input int due);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            r  = ux + uy + int'(ci);
            sr = sx + sy + int'(ci);
        end else begin
            r  = ux - uy - int'(ci);
            sr = sx - sy - int'(ci);
        end
        e.res  = r[7:0];
        e.bout = m ? (r > 255) : (r < 0);
        e.ovf  = (sr > 127) || (sr < -128);
        e.zero = (r[7:0] == 8'd0);
        e.due  = due;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp(input string name, input exp_t e, input logic [7:0] r,
                       input logic bo, input logic ov, input logic z);
        check({name, "_outputs"}, {21'd0, r, bo, ov, z}, {21'd0, e.res, e.bout, e.ovf, e.zero});
        check({name, "_latency"}, cyc, e.due);
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s_unexpected_done actual=1 required=0 (t=%0t)", name, $time);
    endtask

    // Monitors: pop an expectation whenever a unit presents done.
    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) unexpected("d1");
            else begin e = q1.pop_front(); cmp("d1", e, res1, bout1, ovf1, zero1); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) unexpected("d4");
            else begin e = q4.pop_front(); cmp("d4", e, res4, bout4, ovf4, zero4); end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) unexpected("d8");
            else begin e = q8.pop_front(); cmp("d8", e, res8, bout8, ovf8, zero8); end
        end
    end

    // Drive one request; returns #1 after the edge that samples start (E0).
    task automatic issue(input logic [2:0] en, input logic m, input logic [7:0] x,
                         input logic [7:0] y, input logic ci);
        @(negedge clk);
        mode = m; a = x; b = y; bin = ci;
        start1 = en[0]; start4 = en[1]; start8 = en[2];
        @(posedge clk);
        #1;
        if (en[0]) q1.push_back(model(m, x, y, ci, cyc + 8));
        if (en[1]) q4.push_back(model(m, x, y, ci, cyc + 2));
        if (en[2]) q8.push_back(model(m, x, y, ci, cyc + 1));
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((q1.size() + q4.size() + q8.size()) != 0 && i < 40) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("drain_timeout", q1.size() + q4.size() + q8.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] tbl [6];
        logic [17:0] ent;
        tbl[0] = {1'b0, 8'h03, 8'h05, 1'b0};
        tbl[1] = {1'b0, 8'h80, 8'h01, 1'b0};
        tbl[2] = {1'b0, 8'h00, 8'h00, 1'b1};
        tbl[3] = {1'b1, 8'hFF, 8'h01, 1'b0};
        tbl[4] = {1'b1, 8'h7F, 8'h01, 1'b0};
        tbl[5] = {1'b0, 8'hA0, 8'h0B, 1'b0};

        rst = 1'b1;
        start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        mode = 1'b0; bin = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_d1", {busy1, done1, res1, bout1, ovf1, zero1}, 0);
        check("reset_d4", {busy4, done4, res4, bout4, ovf4, zero4}, 0);
        check("reset_d8", {busy8, done8, res8, bout8, ovf8, zero8}, 0);
        rst = 1'b0;

        // First operation with busy/done timing traced cycle by cycle on the bit-serial unit.
        issue(3'b111, 1'b0, 8'h05, 8'h03, 1'b0);
        check("busy_at_e0", busy1, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("busy_done_run", {busy1, done1}, 2'b10);
        end
        @(negedge clk);
        check("busy_done_en", {busy1, done1}, 2'b01);
        @(negedge clk);
        check("busy_done_after", {busy1, done1}, 2'b00);
        drain();

        for (int i = 0; i < 6; i++) begin
            ent = tbl[i];
            issue(3'b111, ent[17], ent[16:9], ent[8:1], ent[0]);
            drain();
        end

        for (int i = 0; i < 30; i++) begin
            issue(3'b111, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            drain();
        end

        // start while busy must be ignored.
        issue(3'b001, 1'b0, 8'h5A, 8'h21, 1'b0);
        repeat (3) @(negedge clk);
        mode = 1'b1; a = 8'hFF; b = 8'h01; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("busy_ignore", busy1, 1);
        drain();
        repeat (12) @(negedge clk);
        check("idle_after_ignore", busy1, 0);

        // start held in the DONE cycle starts the next operation back-to-back.
        issue(3'b001, 1'b1, 8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (done1) break;
        end
        check("done_seen", done1, 1);
        mode = 1'b0; a = 8'hC3; b = 8'h3C; bin = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1;
        q1.push_back(model(1'b0, 8'hC3, 8'h3C, 1'b0, cyc + 8));
        start1 = 1'b0;
        check("busy_b2b", busy1, 1);
        drain();

        // Asynchronous reset at E3 aborts the operation without a done pulse.
        issue(3'b001, 1'b0, 8'h77, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {busy1, done1, res1, bout1, ovf1, zero1}, 0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("idle_after_reset", busy1, 0);
        issue(3'b111, 1'b1, 8'h80, 8'h80, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle add/subtract unit for the ALU datapath.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, LSB digit first, with a carry/borrow chain held in a register.
- Delivers result, carry/borrow-out, signed overflow and zero flags with a start/busy/done handshake.
- Trades latency for area against the combinational ripple path; used where ALU timing or area is constrained.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock cycle; 1 gives bit-serial operation, WIDTH gives single-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  1  0 = subtract (a - b - bin), 1 = add (a + b + bin); captured with start
- a  input  WIDTH  minuend / augend; captured with start
- b  input  WIDTH  subtrahend / addend; captured with start
- bin  input  1  borrow-in (sub) or carry-in (add); captured with start
- busy  output  1  high while in RUN
- done  output  1  single-cycle completion pulse
- result  output  WIDTH  difference or sum
- bout  output  1  borrow-out (sub) or carry-out (add)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  result == 0

Behaviour:
- Reset: rst is asynchronous and active-high. All outputs, the state and the counter go to 0 and the state goes to IDLE. Reset mid-operation aborts the operation; done does not pulse for it.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE after N = WIDTH/DIGIT processing edges.
  - DONE -> RUN on start (back-to-back operation); otherwise DONE -> IDLE.
- Load: at the edge that samples start (E0), capture a and b into shift registers, capture mode, load the chain register with bin, and clear the digit counter.
- RUN, edges E1..EN:
  - Process the low DIGIT bits of the shift registers and the chain bit.
  - Subtract cell: d = x^y^c; borrow = (~x&y)|(y&c)|(~x&c).
  - Add cell: s = x^y^c; carry = (x&y)|(y&c)|(x&c).
  - Digits ripple within the cycle, LSB first.
  - The digit result shifts into the result register from the MSB side; the chain output is registered.
- Completion: at EN, move to DONE and update all outputs.
  - result = the assembled value; bout = the final chain bit.
  - ovf (sub): a[MSB] != b[MSB] and result[MSB] != a[MSB].
  - ovf (add): a[MSB] == b[MSB] and result[MSB] != a[MSB].
  - zero = ~|result.
  - Operand MSBs come from copies captured at E0.
- Timing and latency:
  - done is high for exactly the one cycle between EN and EN+1.
  - busy is high from E0 to EN.
  - Latency from the start-sampling edge to the first done-high cycle is N edges.
- Hold: result, bout, ovf and zero are registered and hold their values until the next completion.
- start while busy: ignored; the in-flight operation is unaffected.
- start in DONE: accepted; done still pulses for the finishing operation and busy rises at the same edge.
- Arithmetic: modulo 2^WIDTH; bout carries the unsigned borrow or carry.
- Counter width: $clog2(N) with a minimum of 1. When N = 1, RUN lasts one edge.
- Illegal parameters: elaboration fails (generate-time error) if WIDTH % DIGIT != 0 or DIGIT < 1.

Decomposition:
- Shared package alu_pkg contains:
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - MODE_SUB=1'b0 and MODE_ADD=1'b1.
- Sub-module digit_addsub (parameter DIGIT):
  - Combinational DIGIT-bit ripple of the add/subtract cells above.
  - Ports: x, y, cin, mode, out, cout.
  - Instantiated once in serial_addsub.
- The FSM, counter and shift registers live in serial_addsub.

Test Plan:
- WIDTH=8, DIGIT=1, sub, a=0x05, b=0x03, bin=0 -> result=0x02, bout=0, ovf=0, zero=0. done high only between E8 and E9; busy high E0..E8.
- Sub, a=0x03, b=0x05 -> result=0xFE, bout=1, ovf=0. Sub, a=0x80, b=0x01 -> result=0x7F, ovf=1, bout=0. Sub, a=0x00, b=0x00, bin=1 -> result=0xFF, bout=1.
- Add, a=0xFF, b=0x01, bin=0 -> result=0x00, bout=1, zero=1, ovf=0. Add, a=0x7F, b=0x01 -> result=0x80, ovf=1.
- DIGIT=4, sub, a=0xA0, b=0x0B -> result=0x95, bout=0; done after 2 RUN edges. DIGIT=8 -> done after 1 edge.
- Sequencing, two parts:
  - start asserted again at E3 with different operands -> ignored; first result is unchanged.
  - start held in the DONE cycle -> second operation begins at the same edge and done pulses again N edges later.
- rst asserted asynchronously mid-RUN at E3 -> busy, result and flags go to 0 immediately; no done pulse. The next start then completes normally.
